alu_issue_ctrl: RTL and testbench

Initiator-side controller for the 32-bit combinational ALU. It accepts operation commands on a valid/ready stream and registers them onto the ALU operand/control ports. One cycle later it captures the ALU result and flags into a response FIFO, which it drains on a valid/ready response stream. Sits between the decode/dispatch logic and the ALU instance, and owns all timing, backpressure and illegal-opcode handling around the ALU.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_rsp_fifo.sv | 77 +++++++
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode map,
// flag bit positions and the response record layout.
package alu_pkg;

   // ALU control codes; anything above OP_LAST_LEGAL makes the ALU drive X
   localparam logic [3:0] OP_EQU        = 4'b0000;
   localparam logic [3:0] OP_LT         = 4'b0001;
   localparam logic [3:0] OP_LTU        = 4'b0010;
   localparam logic [3:0] OP_GT         = 4'b0011;
   localparam logic [3:0] OP_GTU        = 4'b0100;
   localparam logic [3:0] OP_ADD        = 4'b0101;
   localparam logic [3:0] OP_ADDC       = 4'b0110;
   localparam logic [3:0] OP_SUB        = 4'b0111;
   localparam logic [3:0] OP_SUBB       = 4'b1000;
   localparam logic [3:0] OP_OR         = 4'b1001;
   localparam logic [3:0] OP_XOR        = 4'b1010;
   localparam logic [3:0] OP_NOR        = 4'b1011;
   localparam logic [3:0] OP_NOT        = 4'b1100;
   localparam logic [3:0] OP_AND        = 4'b1101;
   localparam logic [3:0] OP_LAST_LEGAL = 4'b1101;

   // Bit positions inside the 4-bit response flag field
   localparam int FLG_ZERO  = 0;
   localparam int FLG_NEG   = 1;
   localparam int FLG_OVF   = 2;
   localparam int FLG_CARRY = 3;

   // Response record for the default 32-bit data / 4-bit tag configuration
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  flags;
      logic [3:0]  tag;
      logic        err;
   } alu_rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding ALU responses.
// The head entry is visible on rd_data whenever valid is high; the output
// reads as zero while empty so nothing stale leaks out after a reset.
module alu_rsp_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             rd_fire_s;
   logic             wr_fire_s;

   // Qualify pushes and pops so the FIFO can never overflow or underflow
   always_comb begin
      rd_fire_s = 1'b0;
      wr_fire_s = 1'b0;
      if (count_r != (AW+1)'(0)) begin
         rd_fire_s = rd_en;
      end else begin
         rd_fire_s = 1'b0;
      end
      if ((count_r < (AW+1)'(DEPTH)) || rd_fire_s) begin
         wr_fire_s = wr_en;
      end else begin
         wr_fire_s = 1'b0;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_fire_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (rd_fire_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({wr_fire_s, rd_fire_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset because reads are gated by valid
   always_ff @(posedge clk) begin
      if (wr_fire_s && !rst) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign valid   = (count_r != (AW+1)'(0));
   assign count   = count_r;
   assign rd_data = valid ? mem_r[rd_ptr_r] : '0;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller wrapped around the combinational 32-bit ALU.
// Commands are registered onto the ALU ports, the ALU result is captured
// one cycle later into a response FIFO, and responses drain in order.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int BITS_SIZE  = 32,
   parameter int CNTRL_SIZE = 4,
   parameter int TAG_W      = 4,
   parameter int RSP_DEPTH  = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CNTRL_SIZE-1:0] cmd_op,
   input  logic [BITS_SIZE-1:0]  cmd_a,
   input  logic [BITS_SIZE-1:0]  cmd_b,
   input  logic                  cmd_cin,
   input  logic [TAG_W-1:0]      cmd_tag,
   output logic [BITS_SIZE-1:0]  alu_a,
   output logic [BITS_SIZE-1:0]  alu_b,
   output logic [CNTRL_SIZE-1:0] alu_cntrl,
   output logic                  alu_cin,
   input  logic [BITS_SIZE-1:0]  alu_out,
   input  logic                  alu_zero,
   input  logic                  alu_ovf,
   input  logic                  alu_neg,
   input  logic                  alu_carry,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [BITS_SIZE-1:0]  rsp_data,
   output logic [3:0]            rsp_flags,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic                  rsp_err,
   output logic [CNT_W-1:0]      op_count,
   output logic [CNT_W-1:0]      err_count
);

   localparam int RSP_W = BITS_SIZE + 4 + TAG_W + 1;
   localparam int CW    = $clog2(RSP_DEPTH) + 1;

   logic                  issue_vld_r;
   logic [TAG_W-1:0]      issue_tag_r;
   logic                  issue_err_r;
   logic [BITS_SIZE-1:0]  alu_a_r;
   logic [BITS_SIZE-1:0]  alu_b_r;
   logic [CNTRL_SIZE-1:0] alu_cntrl_r;
   logic                  alu_cin_r;
   logic [CNT_W-1:0]      op_count_r;
   logic [CNT_W-1:0]      err_count_r;

   logic [CW-1:0]         fifo_count_s;
   logic [CW:0]           occupancy_s;
   logic                  cmd_ready_s;
   logic                  accept_s;
   logic                  illegal_s;
   logic [3:0]            flags_s;
   logic [RSP_W-1:0]      wr_data_s;
   logic [RSP_W-1:0]      rd_data_s;
   logic                  fifo_valid_s;
   logic                  rd_en_s;

   // Admission: only accept when the FIFO plus the in-flight op leave a free slot
   always_comb begin
      occupancy_s = {1'b0, fifo_count_s} + (CW+1)'(issue_vld_r);
      cmd_ready_s = !rst && (occupancy_s < (CW+1)'(RSP_DEPTH));
      accept_s    = cmd_valid && cmd_ready_s;
      illegal_s   = (cmd_op > CNTRL_SIZE'(OP_LAST_LEGAL));
   end

   // Issue register: drive the ALU for exactly one cycle per accepted command,
   // parking it on EQU with zero operands when idle or for illegal codes
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_vld_r <= 1'b0;
         issue_tag_r <= '0;
         issue_err_r <= 1'b0;
         alu_a_r     <= '0;
         alu_b_r     <= '0;
         alu_cntrl_r <= '0;
         alu_cin_r   <= 1'b0;
      end else if (accept_s) begin
         issue_vld_r <= 1'b1;
         issue_tag_r <= cmd_tag;
         issue_err_r <= illegal_s;
         alu_a_r     <= cmd_a;
         alu_b_r     <= cmd_b;
         alu_cntrl_r <= illegal_s ? CNTRL_SIZE'(OP_EQU) : cmd_op;
         alu_cin_r   <= cmd_cin;
      end else begin
         issue_vld_r <= 1'b0;
         issue_tag_r <= '0;
         issue_err_r <= 1'b0;
         alu_a_r     <= '0;
         alu_b_r     <= '0;
         alu_cntrl_r <= '0;
         alu_cin_r   <= 1'b0;
      end
   end

   // Capture: build the response entry from the ALU outputs, or an error record
   always_comb begin
      flags_s            = 4'b0000;
      flags_s[FLG_ZERO]  = alu_zero;
      flags_s[FLG_NEG]   = alu_neg;
      flags_s[FLG_OVF]   = alu_ovf;
      flags_s[FLG_CARRY] = alu_carry;
      wr_data_s          = '0;
      if (issue_err_r) begin
         wr_data_s = {{BITS_SIZE{1'b0}}, 4'b0000, issue_tag_r, 1'b1};
      end else begin
         wr_data_s = {alu_out, flags_s, issue_tag_r, 1'b0};
      end
   end

   // Accepted / illegal command counters, saturating at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count_r  <= '0;
         err_count_r <= '0;
      end else if (accept_s) begin
         if (op_count_r != {CNT_W{1'b1}}) begin
            op_count_r <= op_count_r + CNT_W'(1);
         end
         if (illegal_s && (err_count_r != {CNT_W{1'b1}})) begin
            err_count_r <= err_count_r + CNT_W'(1);
         end
      end
   end

   assign rd_en_s = fifo_valid_s && rsp_ready;

   alu_rsp_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (issue_vld_r),
      .wr_data (wr_data_s),
      .rd_en   (rd_en_s),
      .rd_data (rd_data_s),
      .valid   (fifo_valid_s),
      .count   (fifo_count_s)
   );

   assign cmd_ready = cmd_ready_s;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_cntrl = alu_cntrl_r;
   assign alu_cin   = alu_cin_r;
   assign rsp_valid = fifo_valid_s;
   assign {rsp_data, rsp_flags, rsp_tag, rsp_err} = rd_data_s;
   assign op_count  = op_count_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. The bench plays the ALU itself and
// keeps a transaction-level model: a queue of expected responses plus one
// in-flight slot, updated once per cycle from the command stream.
module tb_alu_issue_ctrl;

   localparam int BITS  = 32;
   localparam int CTL   = 4;
   localparam int TW    = 4;
   localparam int DEPTH = 4;
   localparam int CNTW  = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [CTL-1:0]  cmd_op;
   logic [BITS-1:0] cmd_a;
   logic [BITS-1:0] cmd_b;
   logic            cmd_cin;
   logic [TW-1:0]   cmd_tag;
   logic [BITS-1:0] alu_a;
   logic [BITS-1:0] alu_b;
   logic [CTL-1:0]  alu_cntrl;
   logic            alu_cin;
   logic [BITS-1:0] alu_out;
   logic            alu_zero;
   logic            alu_ovf;
   logic            alu_neg;
   logic            alu_carry;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [BITS-1:0] rsp_data;
   logic [3:0]      rsp_flags;
   logic [TW-1:0]   rsp_tag;
   logic            rsp_err;
   logic [CNTW-1:0] op_count;
   logic [CNTW-1:0] err_count;

   always #5 clk = ~clk;

   alu_issue_ctrl #(
      .BITS_SIZE (BITS), .CNTRL_SIZE (CTL), .TAG_W (TW),
      .RSP_DEPTH (DEPTH), .CNT_W (CNTW)
   ) dut (
      .clk (clk), .rst (rst),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
      .cmd_a (cmd_a), .cmd_b (cmd_b), .cmd_cin (cmd_cin), .cmd_tag (cmd_tag),
      .alu_a (alu_a), .alu_b (alu_b), .alu_cntrl (alu_cntrl), .alu_cin (alu_cin),
      .alu_out (alu_out), .alu_zero (alu_zero), .alu_ovf (alu_ovf),
      .alu_neg (alu_neg), .alu_carry (alu_carry),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
      .rsp_flags (rsp_flags), .rsp_tag (rsp_tag), .rsp_err (rsp_err),
      .op_count (op_count), .err_count (err_count)
   );

   // Behavioural ALU: returns {out, carry, ovf, neg, zero}
   function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic cin);
      logic [32:0] s;
      logic [31:0] o;
      logic c, v, n, z;
      s = '0; o = '0; c = 1'b0; v = 1'b0; n = 1'b0; z = 1'b0;
      case (op)
         4'd0: begin o = a ^ b; z = (a == b); n = o[31]; end
         4'd1: z = ($signed(a) < $signed(b));
         4'd2: z = (a < b);
         4'd3: z = ($signed(a) > $signed(b));
         4'd4: z = (a > b);
         4'd5, 4'd6: begin
            s = {1'b0, a} + {1'b0, b} + ((op == 4'd6) ? {32'd0, cin} : 33'd0);
            o = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (o[31] != a[31]);
         end
         4'd7, 4'd8: begin
            s = {1'b0, a} + {1'b0, ~b} + ((op == 4'd8) ? {32'd0, cin} : 33'd1);
            o = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (o[31] != a[31]);
         end
         4'd9:  o = a | b;
         4'd10: o = a ^ b;
         4'd11: o = ~(a | b);
         4'd12: o = ~a;
         4'd13: o = a & b;
         default: o = 'x;
      endcase
      if (op >= 4'd5) begin
         n = o[31];
         z = (o == 32'd0);
      end
      return {o, c, v, n, z};
   endfunction

   assign {alu_out, alu_carry, alu_ovf, alu_neg, alu_zero} = alu_fn(alu_a, alu_b, alu_cntrl, alu_cin);

   typedef struct {
      logic [31:0] data;
      logic [3:0]  flags;
      logic [3:0]  tag;
      logic        err;
   } rsp_e;

   rsp_e        q[$];
   bit          inflight = 1'b0;
   rsp_e        inflight_e;
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;
   logic [3:0]  exp_ctl = '0;
   logic        exp_cin = 1'b0;
   int          exp_ops = 0;
   int          exp_errs = 0;
   bit          check_en = 1'b0;
   bit          last_ready;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: compare outputs, drive new inputs, advance the model
   task automatic step(input bit r, input bit v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] tag, input bit rr);
      bit          exp_ready;
      bit          accept;
      rsp_e        e;
      logic [35:0] res;
      @(negedge clk);
      if (check_en) begin
         chk("alu_a", alu_a, exp_a);
         chk("alu_b", alu_b, exp_b);
         chk("alu_cntrl", alu_cntrl, exp_ctl);
         chk("alu_cin", alu_cin, exp_cin);
         chk("rsp_valid", rsp_valid, q.size() > 0);
         if (q.size() > 0) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_flags", rsp_flags, q[0].flags);
            chk("rsp_tag", rsp_tag, q[0].tag);
            chk("rsp_err", rsp_err, q[0].err);
         end
         chk("op_count", op_count, exp_ops);
         chk("err_count", err_count, exp_errs);
      end
      rst = r; cmd_valid = v; cmd_op = op; cmd_a = a; cmd_b = b;
      cmd_cin = cin; cmd_tag = tag; rsp_ready = rr;
      #1;
      exp_ready = !r && ((q.size() + int'(inflight)) < DEPTH);
      if (check_en || r) chk("cmd_ready", cmd_ready, exp_ready);
      last_ready = cmd_ready;
      if (r) begin
         q.delete(); inflight = 1'b0; exp_ops = 0; exp_errs = 0;
         exp_a = '0; exp_b = '0; exp_ctl = '0; exp_cin = 1'b0;
         check_en = 1'b1;
      end else begin
         accept = v && exp_ready;
         if (q.size() > 0 && rr) void'(q.pop_front());
         if (inflight) q.push_back(inflight_e);
         inflight = accept;
         if (accept) begin
            if (op > 4'd13) begin
               e = '{32'd0, 4'd0, tag, 1'b1};
               if (exp_errs < 65535) exp_errs++;
            end else begin
               res = alu_fn(a, b, op, cin);
               e = '{res[35:4], res[3:0], tag, 1'b0};
            end
            if (exp_ops < 65535) exp_ops++;
            inflight_e = e;
            exp_a = a; exp_b = b; exp_ctl = (op > 4'd13) ? 4'd0 : op; exp_cin = cin;
         end else begin
            exp_a = '0; exp_b = '0; exp_ctl = '0; exp_cin = 1'b0;
         end
      end
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, rr);
   endtask

   initial begin
      int acc;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_cin = 1'b0; cmd_tag = '0; rsp_ready = 1'b0;

      // Reset and reset-state pins
      step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
      step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
      idle(1'b1);
      chk("reset rsp_valid", rsp_valid, 1'b0);
      chk("reset rsp_data", rsp_data, 32'd0);
      chk("reset rsp_flags", rsp_flags, 4'd0);
      chk("reset rsp_tag", rsp_tag, 4'd0);
      chk("reset rsp_err", rsp_err, 1'b0);
      chk("reset op_count", op_count, 16'd0);
      chk("reset alu_cntrl", alu_cntrl, 4'd0);

      // ADD overflow case
      step(1'b0, 1'b1, 4'b0101, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd3, 1'b1);
      idle(1'b1);
      chk("add alu_cntrl", alu_cntrl, 4'b0101);
      chk("add alu_a", alu_a, 32'h7FFF_FFFF);
      idle(1'b1);
      chk("add rsp_valid", rsp_valid, 1'b1);
      chk("add rsp_data", rsp_data, 32'h8000_0000);
      chk("add rsp_flags", rsp_flags, 4'b0110);
      chk("add rsp_tag", rsp_tag, 4'd3);
      chk("add rsp_err", rsp_err, 1'b0);

      // SUB equal operands; ALU sees the code for exactly one cycle
      step(1'b0, 1'b1, 4'b0111, 32'd5, 32'd5, 1'b0, 4'd4, 1'b1);
      idle(1'b1);
      chk("sub alu_cntrl", alu_cntrl, 4'b0111);
      idle(1'b1);
      chk("sub alu_cntrl after", alu_cntrl, 4'b0000);
      chk("sub rsp_data", rsp_data, 32'd0);
      chk("sub carry/ovf/neg", rsp_flags[3:1], 3'b100);

      // Signed vs unsigned less-than, back to back
      step(1'b0, 1'b1, 4'b0001, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd5, 1'b1);
      step(1'b0, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd6, 1'b1);
      idle(1'b1);
      chk("lt rsp_data", rsp_data, 32'd0);
      chk("lt rsp_flags", rsp_flags, 4'b0001);
      chk("lt rsp_tag", rsp_tag, 4'd5);
      idle(1'b1);
      chk("ltu rsp_flags", rsp_flags, 4'b0000);
      chk("ltu rsp_tag", rsp_tag, 4'd6);

      // Illegal opcode from a clean reset
      step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
      step(1'b0, 1'b1, 4'b1110, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 4'd7, 1'b1);
      idle(1'b1);
      chk("ill alu_cntrl", alu_cntrl, 4'b0000);
      idle(1'b1);
      chk("ill rsp_err", rsp_err, 1'b1);
      chk("ill rsp_data", rsp_data, 32'd0);
      chk("ill rsp_flags", rsp_flags, 4'd0);
      chk("ill rsp_tag", rsp_tag, 4'd7);
      chk("ill err_count", err_count, 16'd1);
      chk("ill op_count", op_count, 16'd1);

      // Backpressure: response side stalled while commands stream in
      acc = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         step(1'b0, 1'b1, 4'(i % 14), $urandom, $urandom, 1'b0, 4'(i + 8), 1'b0);
         if (last_ready) acc++;
      end
      chk("bp accepts", acc, DEPTH);
      chk("bp cmd_ready", cmd_ready, 1'b0);
      for (int i = 0; i < DEPTH + 4; i++)
         step(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0, 4'(i), 1'b1);
      for (int i = 0; i < 8; i++) idle(1'b1);

      // Reset with two FIFO entries and one op in flight
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 4'd5, $urandom, $urandom, 1'b0, 4'(i + 1), 1'b0);
      step(1'b1, 1'b1, 4'd5, 32'd1, 32'd1, 1'b0, 4'd9, 1'b1);
      idle(1'b1);
      chk("mid-rst rsp_valid", rsp_valid, 1'b0);
      chk("mid-rst op_count", op_count, 16'd0);
      chk("mid-rst err_count", err_count, 16'd0);
      for (int i = 0; i < 5; i++) begin
         idle(1'b1);
         chk("mid-rst no stale", rsp_valid, 1'b0);
      end

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
         if ($urandom_range(0, 7) == 0) b = a;
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
              4'($urandom_range(0, 15)), a, b, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6);
      end
      for (int i = 0; i < 10; i++) idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
